// File: rtl/dda_trace_plotter.sv
// Scrolling oscilloscope plotter: each accepted (x1, x2) sample becomes two pixel writes in the
// current column; every DECIM samples the next column is erased and becomes the current one.
module dda_trace_plotter #(
    parameter int          H_RES    = 640,
    parameter int          V_RES    = 480,
    parameter int          Y_CENTER = 240,
    parameter int          Y_SHIFT  = 9,
    parameter int          DECIM    = 1,
    parameter logic [7:0]  COLOR1   = 8'hE0,
    parameter logic [7:0]  COLOR2   = 8'h1C,
    parameter logic [7:0]  BG_COLOR = 8'h00
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic signed [17:0] x1,
    input  logic signed [17:0] x2,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic [9:0]         vga_xCoord,
    output logic [8:0]         vga_yCoord,
    output logic [7:0]         vga_color,
    output logic               w_en,
    input  logic               w_ack,
    output logic               frame_done
);

    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic signed [19:0] YC   = 20'(Y_CENTER);
    localparam logic signed [19:0] YMAX = 20'(V_RES - 1);

    // states: IDLE wait for sample | WR1 x1 pixel | WR2 x2 pixel | ERASE clear next column
    typedef enum logic [1:0] {IDLE, WR1, WR2, ERASE} state_t;

    state_t      state, state_nx;
    logic [8:0]  y1_q, y2_q;
    logic [9:0]  col, next_col;
    logic [DW-1:0] dec_cnt;
    logic [8:0]  row_cnt;
    logic        last_dec, last_row;

    function automatic logic [8:0] row_of(input logic signed [17:0] x);
        logic signed [19:0] xe, y;
        xe = {{2{x[17]}}, x};
        y  = YC - (xe >>> Y_SHIFT);
        if (y < 0)
            return 9'd0;
        else if (y > YMAX)
            return 9'(V_RES - 1);
        else
            return 9'(y);
    endfunction

    assign next_col = (col == 10'(H_RES - 1)) ? 10'd0 : col + 10'd1;
    assign last_dec = (dec_cnt == DW'(DECIM - 1));
    assign last_row = (row_cnt == 9'(V_RES - 1));

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        sample_ready = 1'b0;
        w_en         = 1'b0;
        vga_xCoord   = '0;
        vga_yCoord   = '0;
        vga_color    = '0;
        case (state)
            IDLE: begin
                sample_ready = 1'b1;
                if (sample_valid)
                    state_nx = WR1;
            end
            WR1: begin
                w_en       = 1'b1;
                vga_xCoord = col;
                vga_yCoord = y1_q;
                vga_color  = COLOR1;
                if (w_ack)
                    state_nx = WR2;
            end
            WR2: begin
                w_en       = 1'b1;
                vga_xCoord = col;
                vga_yCoord = y2_q;
                vga_color  = COLOR2;
                if (w_ack)
                    state_nx = last_dec ? ERASE : IDLE;
            end
            ERASE: begin
                w_en       = 1'b1;
                vga_xCoord = next_col;
                vga_yCoord = row_cnt;
                vga_color  = BG_COLOR;
                if (w_ack && last_row)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Rows are mapped at accept time so the write states only mux stored values.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            y1_q       <= '0;
            y2_q       <= '0;
            col        <= '0;
            dec_cnt    <= '0;
            row_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        y1_q <= row_of(x1);
                        y2_q <= row_of(x2);
                    end
                end
                WR2: begin
                    if (w_ack) begin
                        if (last_dec) begin
                            dec_cnt <= '0;
                            row_cnt <= '0;
                        end else begin
                            dec_cnt <= dec_cnt + 1'b1;
                        end
                    end
                end
                ERASE: begin
                    if (w_ack) begin
                        row_cnt <= row_cnt + 1'b1;
                        if (last_row) begin
                            col        <= next_col;
                            frame_done <= (next_col == 10'd0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
